// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM.
// Drives datapath selects/strobes and the ALU control opcode/funct.
module mc_main_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_i,
  input  logic [OP_W-1:0] funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic [OP_W-1:0] ALU_op_o,
  output logic [OP_W-1:0] funct_o,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic            pc_src_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);

  typedef enum logic [ST_W-1:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    R_EXEC,
    R_WB,
    BRANCH,
    ADDI_EXEC,
    ADDI_WB,
    TRAP
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] ALU_ADD = 6'b001000;
  localparam logic [OP_W-1:0] ALU_SUB = 6'b000100;

  state_t          state, state_nx;
  logic [OP_W-1:0] funct_q;
  logic            pc_wr, pc_wr_c, m_rd, m_wr, ir_wr, rf_wr;

  // The branch decision is taken by the datapath from pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state   <= FETCH;
      funct_q <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE)
        funct_q <= funct_i;
    end
  end

  always_comb begin
    state_nx     = FETCH;
    pc_wr        = 1'b0;
    pc_wr_c      = 1'b0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    ir_wr        = 1'b0;
    rf_wr        = 1'b0;
    pc_src_o     = 1'b0;
    i_or_d_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    ALU_op_o     = ALU_ADD;
    funct_o      = '0;
    illegal_o    = 1'b0;
    unique case (state)
      FETCH: begin
        m_rd        = 1'b1;
        alu_src_b_o = 2'b01;
        pc_wr       = mem_ready_i;
        ir_wr       = mem_ready_i;
        state_nx    = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        if (op_i == OP_R)
          state_nx = R_EXEC;
        else if (op_i == OP_LW || op_i == OP_SW)
          state_nx = MEM_ADDR;
        else if (op_i == OP_BEQ)
          state_nx = BRANCH;
        else if (op_i == OP_ADDI)
          state_nx = ADDI_EXEC;
        else
          state_nx = TRAP;
      end
      R_EXEC: begin
        alu_src_a_o = 1'b1;
        ALU_op_o    = OP_R;
        funct_o     = funct_q;
        state_nx    = R_WB;
      end
      R_WB: begin
        rf_wr     = 1'b1;
        reg_dst_o = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nx    = (op_i == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        m_rd     = 1'b1;
        i_or_d_o = 1'b1;
        state_nx = mem_ready_i ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        rf_wr        = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEM_WRITE: begin
        m_wr     = 1'b1;
        i_or_d_o = 1'b1;
        state_nx = mem_ready_i ? FETCH : MEM_WRITE;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        ALU_op_o    = ALU_SUB;
        pc_wr_c     = 1'b1;
        pc_src_o    = 1'b1;
      end
      ADDI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nx    = ADDI_WB;
      end
      ADDI_WB: rf_wr = 1'b1;
      TRAP: begin
        illegal_o = 1'b1;
        state_nx  = TRAP;
      end
      default: state_nx = FETCH;
    endcase
  end

  // Strobes are held off for as long as reset is asserted.
  assign pc_write_o      = pc_wr & rst_n;
  assign pc_write_cond_o = pc_wr_c & rst_n;
  assign mem_read_o      = m_rd & rst_n;
  assign mem_write_o     = m_wr & rst_n;
  assign ir_write_o      = ir_wr & rst_n;
  assign reg_write_o     = rf_wr & rst_n;
  assign state_o         = state;

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Multi-cycle main control FSM for the MIPS datapath. It is the issuing side of the ALU control interface: each cycle it drives the 6-bit ALU opcode and 6-bit funct that the ALU control decoder turns into a 4-bit ALU operation. It also sequences instruction fetch, decode, execute, memory access and writeback, and drives all datapath mux selects and write strobes. Memory accesses use a ready handshake so wait states are tolerated.

Parameters:
OP_W, 6, opcode and funct width
ST_W, 4, state register width

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
op_i  in  6  opcode field from the instruction register
funct_i  in  6  funct field from the instruction register
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes the current read/write this cycle
ALU_op_o  out  6  opcode-space code to ALU control: 000000 = R-type (use funct), 001000 = add, 000100 = sub
funct_o  out  6  funct to ALU control; 000000 unless ALU_op_o = 000000
pc_write_o  out  1  unconditional PC write
pc_write_cond_o  out  1  PC write if zero_i
pc_src_o  out  1  0 = ALU result, 1 = ALUOut register
i_or_d_o  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  instruction register load
reg_write_o  out  1  register file write
reg_dst_o  out  1  0 = rt, 1 = rd
mem_to_reg_o  out  1  0 = ALUOut, 1 = MDR
alu_src_a_o  out  1  0 = PC, 1 = register A
alu_src_b_o  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
illegal_o  out  1  sticky unsupported-opcode flag
state_o  out  4  current state, for debug

Behaviour:
- Reset: while rst_n=0 on a rising edge, state <= FETCH and funct_q <= 0. illegal_o clears. While rst_n is low, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced 0. Reset taken mid-operation aborts the instruction with no further strobes.
- Outputs are Moore-decoded from state. Exception: in FETCH, ir_write_o and pc_write_o equal mem_ready_i. Defaults: all strobes 0, selects 0, ALU_op_o = 001000, funct_o = 000000.
- FETCH (0): mem_read=1, i_or_d=0, src_a=0, src_b=01, ALU add, pc_src=0. Hold until mem_ready_i=1, then go to DECODE.
- DECODE (1): src_a=0, src_b=11, ALU add (branch target into ALUOut). Latch funct_q <= funct_i. Next state by op_i:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000 -> ADDI_EXEC
  - else -> TRAP
- R_EXEC (6): src_a=1, src_b=00, ALU_op=000000, funct_o=funct_q. Next R_WB.
- R_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- MEM_ADDR (2): src_a=1, src_b=10, ALU add. Next MEM_READ if op=100011, else MEM_WRITE.
- MEM_READ (3): mem_read=1, i_or_d=1. Hold until mem_ready_i, then MEM_WB.
- MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WRITE (5): mem_write=1, i_or_d=1. Hold until mem_ready_i, then FETCH.
- BRANCH (8): src_a=1, src_b=00, ALU_op=000100, pc_write_cond=1, pc_src=1. Next FETCH.
- ADDI_EXEC (9): src_a=1, src_b=10, ALU add. Next ADDI_WB.
- ADDI_WB (10): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- TRAP (11): illegal_o=1, all strobes 0. Stays in TRAP until reset.
- Encodings 12-15 are unreachable; if entered, next state is FETCH.
- Zero-wait cycle counts: R-type/addi 4, lw 5, sw 4, beq 3. Each mem_ready_i=0 cycle in a memory state adds 1.
- mem_read_o/mem_write_o stay high and the address select stays stable for the whole wait.
- funct_o is nonzero only in R_EXEC; a funct_i change after DECODE has no effect.

Test Plan:
1. Reset, then release with mem_ready_i=1 -> FETCH first cycle has mem_read_o=1, ir_write_o=1, pc_write_o=1, ALU_op_o=001000, alu_src_b_o=01.
2. op_i=000000, funct_i=100010 (sub), mem_ready_i=1 -> states 0,1,6,7,0. In R_EXEC: ALU_op_o=000000, funct_o=100010. In R_WB: reg_write_o=1, reg_dst_o=1.
3. op_i=100011 with 2 wait cycles in MEM_READ -> states 0,1,2,3,3,3,4. mem_read_o and i_or_d_o stay 1 throughout; MEM_WB has mem_to_reg_o=1. Total 7 cycles.
4. op_i=000100, zero_i=1 and then zero_i=0 -> both have BRANCH with ALU_op_o=000100 and pc_write_cond_o=1, pc_src_o=1; 3 cycles each.
5. op_i=001101 (unsupported) -> DECODE goes to TRAP; illegal_o=1 with no strobes for 20 cycles. rst_n=0 clears it and the FSM restarts at FETCH.
6. rst_n=0 during a MEM_WRITE wait (mem_ready_i=0) -> mem_write_o=0 in the reset cycle, state_o=0 after the edge, and no reg_write_o pulse occurs.
